// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, the execution FSM state type, the
//               writeback-tag flop width and the overflow helper for the
//               ALU execution unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings carried on cop
    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_ADDI = 4'b0011;
    localparam logic [3:0] c_OP_OR   = 4'b0100;
    localparam logic [3:0] c_OP_XOR  = 4'b0101;
    localparam logic [3:0] c_OP_SHL  = 4'b0110;
    localparam logic [3:0] c_OP_SHR  = 4'b0111;
    localparam logic [3:0] c_OP_MUL  = 4'b1000;

    // Flag bits stored next to the destination address in every tag flop
    // (currently only the write-enable bit).
    localparam int c_TAG_FLAG_W = 1;

    // Execution FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } alu_state_t;

    // Two's-complement overflow of an addition given the sign bits of both
    // addends and of the sum. Subtraction passes the inverted subtrahend sign.
    function automatic logic addOvf(input logic aMsb, input logic bMsb, input logic sMsb);
        return (aMsb == bMsb) && (sMsb != aMsb);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative unsigned shift-add multiplier. The first partial
//               product is accumulated on the start edge, the remaining
//               DATA_W-1 on the following enabled edges. done is high in the
//               cycle whose edge applies the final iteration, so product is
//               complete from the next cycle on.
//               Present only when the macro ALU_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef ALU_MUL_EN
module alu_mul_iter #(
    parameter int DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  start,
    input  logic [DATA_W-1:0]     opA,
    input  logic [DATA_W-1:0]     opB,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int                 c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    logic [2*DATA_W-1:0] r_acc;
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_run;

    // Accumulate one multiplier bit per enabled edge; enable low freezes all
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (enable) begin
            if (start) begin
                r_acc    <= opB[0] ? {{DATA_W{1'b0}}, opA} : '0;
                r_mcand  <= {{(DATA_W-1){1'b0}}, opA, 1'b0};
                r_mplier <= opB >> 1;
                r_cnt    <= c_CNT_W'(1);
                r_run    <= 1'b1;
            end else if (r_run) begin
                if (r_mplier[0]) begin
                    r_acc <= r_acc + r_mcand;
                end
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_run <= 1'b0;
                end
            end
        end
    end

    assign done    = r_run && (r_cnt == c_LAST);
    assign product = r_acc;

endmodule
`endif
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Single-issue ALU execution stage with valid/ready handshakes
//               on both sides. Single-cycle ops have latency 1 and sustain
//               one op per cycle; MUL runs iteratively for DATA_W cycles.
//               Macro ALU_MUL_EN: defined -> iterative multiplier and FSM are
//               built; undefined -> opcode 1000 yields 0 like any unused op.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADR_W  = 3,
    parameter int IMM_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] regA,
    input  logic [DATA_W-1:0] regB,
    input  logic [IMM_W-1:0]  imm,
    input  logic [3:0]        cop,
    input  logic [ADR_W-1:0]  destReg_adr,
    input  logic              we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic              OVF,
    output logic [ADR_W-1:0]  destReg_adr_output,
    output logic              we_output,
    output logic              busy
);

    localparam int c_MSB   = DATA_W - 1;
    localparam int c_SH_W  = $clog2(DATA_W);
    localparam int c_TAG_W = ADR_W + c_TAG_FLAG_W;

    logic                r_outValid;
    logic [DATA_W-1:0]   r_result;
    logic                r_ovf;
    logic [c_TAG_W-1:0]  r_tag;

    logic                w_outFree;
    logic                w_accept;
    logic                w_singleLoad;
    logic                w_mulLoad;
    logic [DATA_W-1:0]   w_mulResult;
    logic                w_mulOvf;
    logic [c_TAG_W-1:0]  w_mulTag;
    logic [DATA_W-1:0]   w_immExt;
    logic [c_SH_W-1:0]   w_shAmt;
    logic [DATA_W-1:0]   w_res;
    logic                w_ovf;

    // Output register can take a new value when empty or being drained
    assign w_outFree = ~r_outValid | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_immExt  = DATA_W'(imm);
    assign w_shAmt   = regB[c_SH_W-1:0];

    // Single-cycle datapath: result and overflow for the offered opcode
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (cop)
            c_OP_ADD: begin
                w_res = regA + regB;
                w_ovf = addOvf(regA[c_MSB], regB[c_MSB], w_res[c_MSB]);
            end
            c_OP_SUB: begin
                w_res = regA - regB;
                w_ovf = addOvf(regA[c_MSB], ~regB[c_MSB], w_res[c_MSB]);
            end
            c_OP_AND:  w_res = regA & regB;
            c_OP_ADDI: begin
                w_res = regA + w_immExt;
                w_ovf = addOvf(regA[c_MSB], w_immExt[c_MSB], w_res[c_MSB]);
            end
            c_OP_OR:   w_res = regA | regB;
            c_OP_XOR:  w_res = regA ^ regB;
            c_OP_SHL:  w_res = regA << w_shAmt;
            c_OP_SHR:  w_res = regA >> w_shAmt;
            default:   ;
        endcase
    end

`ifdef ALU_MUL_EN
    alu_state_t          r_state;
    alu_state_t          w_nextState;
    logic                w_mulStart;
    logic                w_mulDone;
    logic [2*DATA_W-1:0] w_product;
    logic [c_TAG_W-1:0]  r_pendTag;

    assign in_ready     = enable & (r_state == IDLE) & w_outFree;
    assign busy         = (r_state != IDLE);
    assign w_mulStart   = w_accept & (cop == c_OP_MUL);
    assign w_singleLoad = w_accept & (cop != c_OP_MUL);
    assign w_mulLoad    = enable & (r_state == MUL_DONE) & w_outFree;
    assign w_mulResult  = w_product[DATA_W-1:0];
    assign w_mulOvf     = |w_product[2*DATA_W-1:DATA_W];
    assign w_mulTag     = r_pendTag;

    // Next-state logic for the multiply sequencing
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:     if (w_mulStart) w_nextState = MUL_RUN;
            MUL_RUN:  if (w_mulDone)  w_nextState = MUL_DONE;
            MUL_DONE: if (w_outFree)  w_nextState = IDLE;
            default:  w_nextState = IDLE;
        endcase
    end

    // FSM state register, frozen while enable is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else if (enable) begin
            r_state <= w_nextState;
        end
    end

    // Writeback tags travel with the multiply until its result is loaded
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pendTag <= '0;
        end else if (w_mulStart) begin
            r_pendTag <= {destReg_adr, we};
        end
    end

    alu_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (w_mulStart),
        .opA     (regA),
        .opB     (regB),
        .done    (w_mulDone),
        .product (w_product)
    );
`else
    assign in_ready     = enable & w_outFree;
    assign busy         = 1'b0;
    assign w_singleLoad = w_accept;
    assign w_mulLoad    = 1'b0;
    assign w_mulResult  = '0;
    assign w_mulOvf     = 1'b0;
    assign w_mulTag     = '0;
`endif

    // Output register: load a new result, or drain on handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_outValid <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_tag      <= '0;
        end else if (enable) begin
            if (w_singleLoad) begin
                r_outValid <= 1'b1;
                r_result   <= w_res;
                r_ovf      <= w_ovf;
                r_tag      <= {destReg_adr, we};
            end else if (w_mulLoad) begin
                r_outValid <= 1'b1;
                r_result   <= w_mulResult;
                r_ovf      <= w_mulOvf;
                r_tag      <= w_mulTag;
            end else if (out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign out_valid          = r_outValid;
    assign alu_result         = r_result;
    assign OVF                = r_ovf;
    assign destReg_adr_output = r_tag[c_TAG_W-1:c_TAG_FLAG_W];
    assign we_output          = r_tag[0];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit (DATA_W=16,
//               ADR_W=3, IMM_W=9). MUL scenarios are built when ALU_MUL_EN is
//               defined; otherwise opcode 1000 is checked as unsupported.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] regA;
    logic [15:0] regB;
    logic [8:0]  imm;
    logic [3:0]  cop;
    logic [2:0]  destReg_adr;
    logic        we;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_result;
    logic        OVF;
    logic [2:0]  destReg_adr_output;
    logic        we_output;
    logic        busy;

    int nChecks = 0;
    int nErrors = 0;

    alu_exec_unit #(
        .DATA_W (16),
        .ADR_W  (3),
        .IMM_W  (9)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .regA               (regA),
        .regB               (regB),
        .imm                (imm),
        .cop                (cop),
        .destReg_adr        (destReg_adr),
        .we                 (we),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .alu_result         (alu_result),
        .OVF                (OVF),
        .destReg_adr_output (destReg_adr_output),
        .we_output          (we_output),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [8:0] im, input logic [2:0] d, input logic w);
        cop         = op;
        regA        = a;
        regB        = b;
        imm         = im;
        destReg_adr = d;
        we          = w;
        in_valid    = 1'b1;
    endtask

    // One single-cycle op with out_ready high: accept, then check the result
    task automatic runAlu(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [8:0] im, input logic [2:0] d,
                          input logic w, input logic [15:0] expRes, input logic expOvf);
        offer(op, a, b, im, d, w);
        #1;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".result"}, alu_result, expRes);
        check({tag, ".ovf"}, OVF, expOvf);
        check({tag, ".dest"}, destReg_adr_output, d);
        check({tag, ".we"}, we_output, w);
    endtask

`ifdef ALU_MUL_EN
    // Count cycles with busy high after a MUL accept; optionally hold enable
    // low for 4 edges starting at busy-cycle freezeAt (0 = no freeze).
    task automatic waitMul(input int freezeAt, output int n);
        n = 0;
        while (busy === 1'b1 && n < 60) begin
            n++;
            if (n == freezeAt)     enable = 1'b0;
            if (n == freezeAt + 4) enable = 1'b1;
            if (in_ready !== 1'b0) check("mul.in_ready_low", in_ready, 1'b0);
            tick();
        end
        enable = 1'b1;
    endtask
`endif

    initial begin
        int n;
        int seen;
        reset = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        regA = '0; regB = '0; imm = '0; cop = '0; destReg_adr = '0; we = 1'b0;
        tick();
        tick();
        check("rst.valid", out_valid, 1'b0);
        check("rst.result", alu_result, 16'h0000);
        check("rst.ovf", OVF, 1'b0);
        check("rst.dest", destReg_adr_output, 3'd0);
        check("rst.we", we_output, 1'b0);
        check("rst.busy", busy, 1'b0);
        reset = 1'b1;
        #1;
        check("idle.in_ready", in_ready, 1'b1);

        // Directed single-cycle vectors
        runAlu("add_ovf",  4'b0000, 16'h7FFF, 16'h0001, 9'h000, 3'd5, 1'b1, 16'h8000, 1'b1);
        runAlu("addi",     4'b0011, 16'h0001, 16'hFFFF, 9'h1FF, 3'd2, 1'b0, 16'h0200, 1'b0);
        runAlu("addi_ovf", 4'b0011, 16'h7FFF, 16'h0000, 9'h001, 3'd1, 1'b1, 16'h8000, 1'b1);
        runAlu("add_carry",4'b0000, 16'hFFFF, 16'h0001, 9'h000, 3'd3, 1'b1, 16'h0000, 1'b0);
        runAlu("sub_ovf",  4'b0001, 16'h8000, 16'h0001, 9'h000, 3'd4, 1'b0, 16'h7FFF, 1'b1);
        runAlu("sub",      4'b0001, 16'h0005, 16'h0003, 9'h000, 3'd6, 1'b1, 16'h0002, 1'b0);
        runAlu("and",      4'b0010, 16'hF0F0, 16'h3C3C, 9'h000, 3'd7, 1'b1, 16'h3030, 1'b0);
        runAlu("or",       4'b0100, 16'hF0F0, 16'h0F01, 9'h000, 3'd0, 1'b1, 16'hFFF1, 1'b0);
        runAlu("xor",      4'b0101, 16'hAAAA, 16'hFFFF, 9'h000, 3'd1, 1'b0, 16'h5555, 1'b0);
        runAlu("shl",      4'b0110, 16'h0001, 16'h0013, 9'h000, 3'd2, 1'b1, 16'h0008, 1'b0);
        runAlu("shr",      4'b0111, 16'h8000, 16'h000F, 9'h000, 3'd3, 1'b1, 16'h0001, 1'b0);
        runAlu("bad_op",   4'b1111, 16'h1234, 16'h0001, 9'h000, 3'd4, 1'b1, 16'h0000, 1'b0);

        // No new op: result drains the cycle after the handshake
        tick();
        check("drain.valid", out_valid, 1'b0);

        // Back-to-back accepts with out_ready high: one op per cycle
        runAlu("b2b_1", 4'b0000, 16'h0010, 16'h0020, 9'h000, 3'd1, 1'b1, 16'h0030, 1'b0);
        runAlu("b2b_2", 4'b0000, 16'h0100, 16'h0200, 9'h000, 3'd2, 1'b0, 16'h0300, 1'b0);

        // Backpressure: first result held for 3 cycles, second op waits
        tick();
        out_ready = 1'b0;
        runAlu("bp_1", 4'b0000, 16'h0001, 16'h0001, 9'h000, 3'd5, 1'b1, 16'h0002, 1'b0);
        offer(4'b0000, 16'h0003, 16'h0004, 9'h000, 3'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.in_ready", in_ready, 1'b0);
            tick();
            check("bp.hold_valid", out_valid, 1'b1);
            check("bp.hold_result", alu_result, 16'h0002);
            check("bp.hold_dest", destReg_adr_output, 3'd5);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_2.valid", out_valid, 1'b1);
        check("bp_2.result", alu_result, 16'h0007);
        check("bp_2.dest", destReg_adr_output, 3'd6);
        tick();
        check("bp.drain", out_valid, 1'b0);

        // enable low freezes the output register and ignores out_ready
        runAlu("en_op", 4'b0101, 16'h00FF, 16'h0F0F, 9'h000, 3'd7, 1'b1, 16'h0FF0, 1'b0);
        enable = 1'b0;
        offer(4'b0000, 16'h1111, 16'h1111, 9'h000, 3'd1, 1'b0);
        #1;
        check("en.in_ready", in_ready, 1'b0);
        tick();
        tick();
        check("en.hold_valid", out_valid, 1'b1);
        check("en.hold_result", alu_result, 16'h0FF0);
        in_valid = 1'b0;
        enable = 1'b1;
        tick();
        check("en.drain", out_valid, 1'b0);

        // Reset wins over enable low
        runAlu("rp_op", 4'b0000, 16'h0002, 16'h0002, 9'h000, 3'd3, 1'b1, 16'h0004, 1'b0);
        enable = 1'b0;
        reset  = 1'b0;
        tick();
        reset  = 1'b1;
        enable = 1'b1;
        check("rstpri.valid", out_valid, 1'b0);
        check("rstpri.result", alu_result, 16'h0000);

`ifdef ALU_MUL_EN
        // MUL 0x0100*0x0100: 16 busy cycles, low half 0, overflow set
        offer(4'b1000, 16'h0100, 16'h0100, 9'h000, 3'd6, 1'b1);
        #1;
        check("mul1.in_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("mul1.busy", busy, 1'b1);
        waitMul(0, n);
        check("mul1.cycles", n, 16);
        check("mul1.valid", out_valid, 1'b1);
        check("mul1.result", alu_result, 16'h0000);
        check("mul1.ovf", OVF, 1'b1);
        check("mul1.dest", destReg_adr_output, 3'd6);
        check("mul1.we", we_output, 1'b1);
        tick();

        // MUL 0xFFFF*0xFFFF = 0xFFFE0001
        offer(4'b1000, 16'hFFFF, 16'hFFFF, 9'h000, 3'd2, 1'b0);
        tick();
        in_valid = 1'b0;
        waitMul(0, n);
        check("mul2.result", alu_result, 16'h0001);
        check("mul2.ovf", OVF, 1'b1);
        check("mul2.dest", destReg_adr_output, 3'd2);
        tick();

        // Reset mid-multiply: aborted, nothing emitted
        offer(4'b1000, 16'h0003, 16'h0005, 9'h000, 3'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mulrst.busy", busy, 1'b0);
        check("mulrst.valid", out_valid, 1'b0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid === 1'b1 || alu_result === 16'h000F) seen++;
        end
        check("mulrst.no_result", seen, 0);

        // enable low for 4 cycles mid-multiply delays completion by 4
        offer(4'b1000, 16'h0003, 16'h0005, 9'h000, 3'd3, 1'b0);
        tick();
        in_valid = 1'b0;
        waitMul(3, n);
        check("mulen.cycles", n, 20);
        check("mulen.valid", out_valid, 1'b1);
        check("mulen.result", alu_result, 16'h000F);
        check("mulen.ovf", OVF, 1'b0);
        check("mulen.dest", destReg_adr_output, 3'd3);
`else
        // Without the multiplier, opcode 1000 is an unsupported single-cycle op
        runAlu("mul_off", 4'b1000, 16'h0003, 16'h0005, 9'h000, 3'd4, 1'b1, 16'h0000, 1'b0);
        check("mul_off.busy", busy, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    // Global time bound in case the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
